packet_receiver: RTL and testbench



---
 rtl/packet_receiver.sv | 245 ++++++++++++++++++++++++
 tb/tb_packet_receiver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/packet_receiver.sv
// packet_receiver: deframes the serial link from the peer labkit into
// 16-word x 16-bit packets. Each packet is a sync word, 16 payload words
// and a checksum word. Payload goes into the back half of a double-buffered
// bank. The banks swap only once the checksum matches, so the consumer only
// ever reads a complete, verified packet.
module packet_receiver #(
    parameter int          CLKS_PER_BIT = 64,
    parameter logic [15:0] SYNC_WORD    = 16'h6111,
    parameter int          TIMEOUT_CLKS = 4096
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        serial_in,
    input  logic [3:0]  incoming_packet_read_index,
    output logic [15:0] incoming_packet_read_data,
    output logic        incoming_packet_new,
    output logic        packet_error,
    output logic [7:0]  packets_received
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK} pkt_state_t;

    // Synchronizer and edge-detect history. These idle high like the line.
    logic sync1_q, sync_in_q, sync_prev_q;

    bit_state_t       bstate_q, bstate_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [3:0]       bidx_q, bidx_d;
    logic [15:0]      shift_q, shift_d;
    logic             word_valid_s, frame_err_s;

    pkt_state_t       pstate_q, pstate_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [15:0]      csum_q, csum_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             fsel_q, fsel_d;
    logic             fvalid_q, fvalid_d;
    logic [7:0]       count_q, count_d;
    logic             new_q, new_d;
    logic             err_q, err_d;
    logic             bank_we_s;

    // Bank storage carries no reset; front_valid masks stale contents.
    logic [15:0] mem_q [2][16];

    // Two-flop synchronizer plus one extra stage for falling-edge detection.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q     <= 1'b1;
            sync_in_q   <= 1'b1;
            sync_prev_q <= 1'b1;
        end else begin
            sync1_q     <= serial_in;
            sync_in_q   <= sync1_q;
            sync_prev_q <= sync_in_q;
        end
    end

    // Bit FSM next state. Word and error strobes fire on the stop-bit sample.
    always_comb begin
        bstate_d     = bstate_q;
        bcnt_d       = bcnt_q;
        bidx_d       = bidx_q;
        shift_d      = shift_q;
        word_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        case (bstate_q)
            B_IDLE: begin
                if (sync_prev_q && !sync_in_q) begin
                    bstate_d = B_START;
                    bcnt_d   = '0;
                end else begin
                    bstate_d = B_IDLE;
                end
            end
            B_START: begin
                if (bcnt_q == HALF_M1) begin
                    bcnt_d   = '0;
                    bidx_d   = 4'd0;
                    // A line that is high again at mid-start-bit was a glitch.
                    bstate_d = sync_in_q ? B_IDLE : B_DATA;
                end else begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                end
            end
            B_DATA: begin
                if (bcnt_q == FULL_M1) begin
                    bcnt_d  = '0;
                    shift_d = {shift_q[14:0], sync_in_q};
                    if (bidx_q == 4'd15) begin
                        bstate_d = B_STOP;
                    end else begin
                        bidx_d = bidx_q + 4'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                end
            end
            B_STOP: begin
                if (bcnt_q == FULL_M1) begin
                    word_valid_s = sync_in_q;
                    frame_err_s  = !sync_in_q;
                    // Return to IDLE now so the next start bit can be seen next cycle.
                    bstate_d     = B_IDLE;
                    bcnt_d       = '0;
                end else begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                end
            end
            default: begin
                bstate_d = B_IDLE;
                bcnt_d   = '0;
            end
        endcase
    end

    // Bit FSM state registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bstate_q <= B_IDLE;
            bcnt_q   <= '0;
            bidx_q   <= 4'd0;
            shift_q  <= 16'h0000;
        end else begin
            bstate_q <= bstate_d;
            bcnt_q   <= bcnt_d;
            bidx_q   <= bidx_d;
            shift_q  <= shift_d;
        end
    end

    // Packet FSM: hunt for sync, collect payload, verify the checksum, police timeouts.
    always_comb begin
        pstate_d  = pstate_q;
        wcnt_d    = wcnt_q;
        csum_d    = csum_q;
        tmo_d     = tmo_q;
        fsel_d    = fsel_q;
        fvalid_d  = fvalid_q;
        count_d   = count_q;
        new_d     = 1'b0;
        err_d     = 1'b0;
        bank_we_s = 1'b0;
        case (pstate_q)
            P_HUNT: begin
                tmo_d = '0;
                if (word_valid_s && (shift_q == SYNC_WORD)) begin
                    pstate_d = P_PAYLOAD;
                    wcnt_d   = 4'd0;
                    csum_d   = 16'h0000;
                end else begin
                    pstate_d = P_HUNT;
                end
            end
            P_PAYLOAD, P_CHECK: begin
                if (frame_err_s) begin
                    err_d    = 1'b1;
                    pstate_d = P_HUNT;
                end else if (word_valid_s) begin
                    tmo_d = '0;
                    if (pstate_q == P_PAYLOAD) begin
                        bank_we_s = 1'b1;
                        csum_d    = csum_q + shift_q;
                        wcnt_d    = wcnt_q + 4'd1;
                        pstate_d  = (wcnt_q == 4'd15) ? P_CHECK : P_PAYLOAD;
                    end else if (shift_q == csum_q) begin
                        fsel_d   = ~fsel_q;
                        fvalid_d = 1'b1;
                        count_d  = count_q + 8'd1;
                        new_d    = 1'b1;
                        pstate_d = P_HUNT;
                    end else begin
                        err_d    = 1'b1;
                        pstate_d = P_HUNT;
                    end
                end else if (bstate_q == B_IDLE) begin
                    if (tmo_q == TMO_LAST) begin
                        err_d    = 1'b1;
                        pstate_d = P_HUNT;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end else begin
                    tmo_d = tmo_q;
                end
            end
            default: begin
                pstate_d = P_HUNT;
            end
        endcase
    end

    // Packet FSM state, bank select and registered output pulses.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pstate_q <= P_HUNT;
            wcnt_q   <= 4'd0;
            csum_q   <= 16'h0000;
            tmo_q    <= '0;
            fsel_q   <= 1'b0;
            fvalid_q <= 1'b0;
            count_q  <= 8'd0;
            new_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pstate_q <= pstate_d;
            wcnt_q   <= wcnt_d;
            csum_q   <= csum_d;
            tmo_q    <= tmo_d;
            fsel_q   <= fsel_d;
            fvalid_q <= fvalid_d;
            count_q  <= count_d;
            new_q    <= new_d;
            err_q    <= err_d;
        end
    end

    // Payload words land in the back bank, which the consumer never sees.
    always_ff @(posedge clock) begin
        if (reset_n && bank_we_s) begin
            mem_q[~fsel_q][wcnt_q] <= shift_q;
        end
    end

    // Combinational front-bank read, masked until the first verified packet.
    always_comb begin
        if (fvalid_q) begin
            incoming_packet_read_data = mem_q[fsel_q][incoming_packet_read_index];
        end else begin
            incoming_packet_read_data = 16'h0000;
        end
    end

    assign incoming_packet_new = new_q;
    assign packet_error        = err_q;
    assign packets_received    = count_q;

endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver with CLKS_PER_BIT=16. Expected
// new/error events go into a queue when their packets are driven. A monitor
// records the observed pulses, and settle() matches the two lists.
module tb_packet_receiver;

    localparam int CPB  = 16;
    localparam int WORD = 18 * CPB;              // cycles per transmitted word
    localparam int LAT  = 17 * CPB + CPB / 2 + 3; // word start -> pulse cycle

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        serial_in = 1'b1;
    logic [3:0]  rd_idx = 4'd0;
    logic [15:0] rd_data;
    logic        pkt_new;
    logic        pkt_err;
    logic [7:0]  pkt_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct { bit is_new; int cnt; int lo; int hi; } exp_t;
    typedef struct { bit is_new; int cnt; int at; } obs_t;
    exp_t exp_q[$];
    obs_t obs_q[$];
    int   obs_rd = 0;

    packet_receiver #(.CLKS_PER_BIT(CPB), .SYNC_WORD(16'h6111), .TIMEOUT_CLKS(4096)) dut (
        .clock                      (clock),
        .reset_n                    (reset_n),
        .serial_in                  (serial_in),
        .incoming_packet_read_index (rd_idx),
        .incoming_packet_read_data  (rd_data),
        .incoming_packet_new        (pkt_new),
        .packet_error               (pkt_err),
        .packets_received           (pkt_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every observed pulse together with the cycle it appeared in.
    always @(negedge clock) begin
        if (reset_n && (pkt_new || pkt_err)) begin
            obs_q.push_back('{pkt_new, int'(pkt_count), cyc});
        end
    end

    task automatic chk(string tag, int got, int expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic send_word(logic [15:0] w, logic stop_bit);
        serial_in = 1'b0;
        repeat (CPB) @(posedge clock);
        #1;
        for (int i = 15; i >= 0; i--) begin
            serial_in = w[i];
            repeat (CPB) @(posedge clock);
            #1;
        end
        serial_in = stop_bit;
        repeat (CPB) @(posedge clock);
        #1;
        serial_in = 1'b1;
    endtask

    task automatic send_packet(logic [15:0] pay, logic [15:0] cs);
        send_word(16'h6111, 1'b1);
        for (int i = 0; i < 16; i++) send_word(pay, 1'b1);
        send_word(cs, 1'b1);
    endtask

    task automatic check_bank(string tag, logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            chk(tag, int'(rd_data), int'(v));
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for the expected events, then compare them in order.
    task automatic settle(int budget);
        int n = 0;
        while ((obs_q.size() - obs_rd) < exp_q.size() && n < budget) begin
            @(posedge clock);
            n++;
        end
        idle(30);
        chk("event_count", obs_q.size() - obs_rd, exp_q.size());
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            exp_t e;
            obs_t o;
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            chk("event_kind", int'(o.is_new), int'(e.is_new));
            chk("event_count_out", o.cnt, e.cnt);
            if (e.lo == e.hi) chk("event_cycle", o.at, e.lo);
            else chk("event_window", int'(o.at >= e.lo && o.at <= e.hi), 1);
        end
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    initial begin
        int t0;
        // Reset.
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("reset_new", int'(pkt_new), 0);
        chk("reset_err", int'(pkt_err), 0);
        chk("reset_count", int'(pkt_count), 0);
        check_bank("reset_read", 16'h0000);
        idle(5);

        // Good packet of 5555.
        t0 = cyc;
        exp_q.push_back('{1'b1, 1, t0 + 17 * WORD + LAT, t0 + 17 * WORD + LAT});
        send_packet(16'h5555, 16'h5550);
        settle(200);
        check_bank("read_5555", 16'h5555);
        chk("count_1", int'(pkt_count), 1);

        // Bad checksum: error, front bank untouched.
        t0 = cyc;
        exp_q.push_back('{1'b0, 1, t0 + 17 * WORD + LAT, t0 + 17 * WORD + LAT});
        send_packet(16'hAAAA, 16'h0000);
        settle(200);
        check_bank("read_after_bad_cs", 16'h5555);
        chk("count_still_1", int'(pkt_count), 1);

        // Same payload with the right checksum.
        t0 = cyc;
        exp_q.push_back('{1'b1, 2, t0 + 17 * WORD + LAT, t0 + 17 * WORD + LAT});
        send_packet(16'hAAAA, 16'hAAA0);
        settle(200);
        check_bank("read_aaaa", 16'hAAAA);
        chk("count_2", int'(pkt_count), 2);

        // Framing error on payload word 7 (transmitted word 8).
        t0 = cyc;
        exp_q.push_back('{1'b0, 2, t0 + 8 * WORD + LAT, t0 + 8 * WORD + LAT});
        send_word(16'h6111, 1'b1);
        for (int i = 0; i < 7; i++) send_word(16'h0F0F, 1'b1);
        send_word(16'h0F0F, 1'b0);
        idle(40);
        settle(200);
        check_bank("read_after_frame_err", 16'hAAAA);
        t0 = cyc;
        exp_q.push_back('{1'b1, 3, t0 + 17 * WORD + LAT, t0 + 17 * WORD + LAT});
        send_packet(16'h1111, 16'h1110);
        settle(200);
        check_bank("read_1111", 16'h1111);

        // Short glitch and stray words in HUNT: silence expected.
        serial_in = 1'b0;
        idle(4);
        serial_in = 1'b1;
        idle(100);
        send_word(16'h1234, 1'b1);
        send_word(16'hABCD, 1'b1);
        settle(100);
        chk("count_after_noise", int'(pkt_count), 3);

        // Header plus 5 payload words, then silence until timeout.
        t0 = cyc + 5 * WORD + LAT + 4096;
        exp_q.push_back('{1'b0, 3, t0 - 8, t0 + 8});
        send_word(16'h6111, 1'b1);
        for (int i = 0; i < 5; i++) send_word(16'h2222, 1'b1);
        settle(5000);
        check_bank("read_after_timeout", 16'h1111);

        // Reset pulse in the middle of a payload.
        send_word(16'h6111, 1'b1);
        for (int i = 0; i < 3; i++) send_word(16'h7777, 1'b1);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        chk("mid_reset_count", int'(pkt_count), 0);
        chk("mid_reset_new", int'(pkt_new), 0);
        chk("mid_reset_err", int'(pkt_err), 0);
        check_bank("mid_reset_read", 16'h0000);
        idle(10);
        t0 = cyc;
        exp_q.push_back('{1'b1, 1, t0 + 17 * WORD + LAT, t0 + 17 * WORD + LAT});
        send_packet(16'h3333, 16'h3330);
        settle(200);
        check_bank("read_3333", 16'h3333);
        chk("count_after_reset", int'(pkt_count), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
